// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared types and constants for the sequential CLA adder
package cla_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - combinational 4-bit propagate/generate carry-lookahead slice
module cla4_slice
  import cla_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W:0]   w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Every carry is a flat function of P/G and cin, no ripple inside the slice
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[SLICE_W-1:0];
  assign o_cout = w_c[SLICE_W];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// rtl/cla_seq_adder_ctrl.sv - nibble-serial adder sequencer; CLA_SEQ_SUBTRACT_EN adds in_sub
module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CLA_SEQ_SUBTRACT_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NSLICE = calc_nslice(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_b_in;
  logic               w_cin_in;
  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);

`ifdef CLA_SEQ_SUBTRACT_EN
  // A - B as A + ~B + 1; cout=1 then means no borrow
  assign w_b_in   = in_sub ? ~in_b : in_b;
  assign w_cin_in = in_sub ? 1'b1 : in_cin;
`else
  assign w_b_in   = in_b;
  assign w_cin_in = in_cin;
`endif

  assign w_a_nib = r_a[SLICE_W*r_idx +: SLICE_W];
  assign w_b_nib = r_b[SLICE_W*r_idx +: SLICE_W];

  cla4_slice u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    busy      = (r_state == RUN) || (r_state == DONE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= w_b_in;
      r_carry <= w_cin_in;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[SLICE_W*r_idx +: SLICE_W] <= w_slice_sum;
      r_carry <= w_slice_cout;
      if (w_last) begin
        r_cout <= w_slice_cout;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign out_sum  = r_sum;
  assign out_cout = r_cout;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb/tb_cla_seq_adder_ctrl.sv - scoreboard bench for cla_seq_adder_ctrl
module tb_cla_seq_adder_ctrl;

  localparam int WIDTH  = 32;
  localparam int NSLICE = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
`ifdef CLA_SEQ_SUBTRACT_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] sb[$];

  cla_seq_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef CLA_SEQ_SUBTRACT_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on WIDTH+1 bits
  function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic cin, input logic sub);
    logic [WIDTH:0] r;
    if (sub) begin
      r[WIDTH-1:0] = a - b;
      r[WIDTH]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end
    return r;
  endfunction

  // Monitor: every completed output handshake must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 64'(out_sum), 64'hDEAD);
        end else begin
          check("result", 64'({out_cout, out_sum}), 64'(sb.pop_front()));
        end
      end
    end
  end

  task automatic wait_in_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic sub, input bit pulse, input int hold);
    int cnt;
    logic [WIDTH:0] held;
    wait_in_ready();
    in_a = a; in_b = b; in_cin = cin;
`ifdef CLA_SEQ_SUBTRACT_EN
    in_sub = sub;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(ref_result(a, b, cin, sub));
    #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      check("run_flags", 64'({in_ready, busy}), 64'b01);
      if (pulse && cnt == 2) begin
        in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      cnt++;
    end
    check("latency", 64'(cnt), 64'(NSLICE));
    held = {out_cout, out_sum};
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_stable", 64'({out_valid, in_ready, out_cout, out_sum}), 64'({2'b10, held}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release", 64'({out_valid, in_ready, busy}), 64'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
`ifdef CLA_SEQ_SUBTRACT_EN
    in_sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({in_ready, busy, out_valid, out_cout, out_sum}), 64'({3'b100, 1'b0, 32'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 0);
    do_add(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 5);

    // Reset in the middle of RUN, after three nibbles have been processed
    wait_in_ready();
    in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    sb.push_back(ref_result(in_a, in_b, in_cin, 1'b0));
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("mid_reset", 64'({in_ready, busy, out_valid, out_cout, out_sum}), 64'({3'b100, 1'b0, 32'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NSLICE + 2; k++) begin
      @(posedge clk); #1;
      check("no_valid_after_reset", 64'({out_valid, in_ready}), 64'b01);
    end
    do_add(32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 1);

`ifdef CLA_SEQ_SUBTRACT_EN
    do_add(32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 0);
    do_add(32'd7, 32'd5, 1'b0, 1'b1, 1'b0, 2);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rsub;
      ra = $urandom;
      rb = (n % 5 == 0) ? ~ra : WIDTH'($urandom);
      rsub = 1'b0;
`ifdef CLA_SEQ_SUBTRACT_EN
      rsub = 1'($urandom);
`endif
      do_add(ra, rb, 1'($urandom), rsub, bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    repeat (NSLICE + 4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
